alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised RISC-V execute-stage ALU, the next generation of the single-cycle combinational ALU. It adds registered outputs, a start/busy/done handshake, XOR, unsigned compare, and shift operations, plus iterative multi-cycle multiply and unsigned divide/remainder. It sits between the register-file read stage and writeback, and the controller stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, at least 8.
- `ERR_VAL`, default 32'hDEADBEEF (low WIDTH bits): Result for an illegal Ctrl.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request; sampled only while `busy`=0.
- `Ctrl`  in  4: operation select.
- `SrcA`  in  WIDTH: operand A; latched on accept.
- `SrcB`  in  WIDTH: operand B; latched on accept.
- `Result`  out  WIDTH: registered result; holds until the next completion.
- `zero`  out  1: registered, 1 when Result==0; updates with Result.
- `err`  out  1: registered, 1 when the last completed op had an illegal Ctrl.
- `busy`  out  1: multi-cycle op in progress; `start` is ignored while high.
- `done`  out  1: one-cycle pulse in the cycle Result/zero/err are new.

## Operation
- Ctrl encoding:
  - 0000 add; 0001 sub.
  - 0010 and; 0011 or; 0100 xor (all bitwise).
  - 0101 slt (signed); 0110 sltu. Both return 1 or 0, zero-extended.
  - 0111 sll; 1000 srl; 1001 sra. Shift amount = SrcB[log2(WIDTH)-1:0]; upper bits are ignored.
  - 1010 mul: low WIDTH bits of A*B.
  - 1011 mulhu: high WIDTH bits of unsigned A*B.
  - 1100 divu; 1101 remu.
  - 1110, 1111: illegal. Result=ERR_VAL, err=1.
- Add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
- States: IDLE and CALC.
  - IDLE with start=1:
    - single-cycle op (0000–1001, 1110, 1111): the result is registered at the accepting edge; stay in IDLE.
    - mul/mulhu/divu/remu: latch the operands, load the iteration counter with WIDTH, go to CALC.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle; the counter decrements.
    - On the final step (counter 1→0): register Result, go to IDLE, pulse done.
- Multiply: unsigned 2·WIDTH-bit product; mul and mulhu select the low or high half.
- Divide by zero follows the RISC-V spec, with no early exit:
  - divu returns all ones.
  - remu returns the dividend.
- err is cleared by any legal completion.
- start while busy=1 is ignored: not queued, no error.
- A new op may be accepted in the same cycle done=1, because the block is already in IDLE.
- Operand or Ctrl changes while busy have no effect.
- Reset values (applied immediately on rst, including mid-CALC, which aborts the op): state IDLE, Result=0, zero=1, err=0, busy=0, done=0, counter=0.

## Timing
- Single-cycle ops (accept at edge N):
  - Result/zero/err/done valid after edge N; done=1 for exactly one cycle.
  - busy stays 0.
- Multi-cycle ops (accept at edge N):
  - busy=1 after edge N through edge N+WIDTH-1.
  - At edge N+WIDTH: Result valid, done=1, busy=0.
  - Latency is WIDTH cycles for WIDTH=32 (32 cycles), including divide by zero.
- Back-to-back single-cycle ops: one per cycle; done stays high across consecutive completions.
- No combinational path from inputs to outputs.

## Test plan
- **Reset defaults:** reset, then start=1, Ctrl=0000, A=5, B=7 → next cycle Result=12, done=1, zero=0.
- **Bitwise and compare:**
  - and, or, xor with A=32'hF0F0_00FF, B=32'h0FF0_0F0F → 32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0.
  - slt(-1,1)=1; sltu(-1,1)=0.
  - sra(32'h8000_0000, B=32'h21) = 32'hC000_0000.
- **Multiply:** mul A=32'hFFFF_FFFF, B=2 → busy 32 cycles, then Result=32'hFFFF_FFFE and done one cycle; mulhu, same operands → Result=1.
- **Divide:**
  - divu 100/7 = 14; remu 100/7 = 2.
  - divu x/0 = 32'hFFFF_FFFF; remu 9/0 = 9.
  - Each takes 32 cycles.
  - start pulses while busy are ignored.
  - A start in the done cycle is accepted.
- **Illegal op and reset:**
  - Ctrl=1111 → Result=32'hDEADBEEF, err=1, zero=0.
  - A following add clears err.
  - Assert rst mid-divu at cycle 10 → outputs return to reset values at once, and there is no done pulse.
- **Parameter sweep:** WIDTH=8, ERR_VAL=8'hEF: mul 8'h10*8'h10 → 8'h00 with zero=1 after 8 cycles, mulhu → 8'h01.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring unsigned divide behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] ERR_VAL = WIDTH'(32'hDEADBEEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       Ctrl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, err_q, err_d, done_q, done_d;
  logic             load;

  // Iteration datapath: hi = partial product / remainder, lo = multiplier / quotient
  logic [WIDTH-1:0] hi_q, lo_q, dv_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   sum, rsh, rdiff;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [SHW-1:0]   shamt;
  logic             is_multi;

  assign is_multi = (Ctrl >= 4'hA) && (Ctrl <= 4'hD);
  assign shamt    = SrcB[SHW-1:0];

  always_comb begin
    alu_res = ERR_VAL;
    alu_ill = 1'b0;
    case (Ctrl)
      4'h0: alu_res = SrcA + SrcB;
      4'h1: alu_res = SrcA - SrcB;
      4'h2: alu_res = SrcA & SrcB;
      4'h3: alu_res = SrcA | SrcB;
      4'h4: alu_res = SrcA ^ SrcB;
      4'h5: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'h6: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      4'h7: alu_res = SrcA << shamt;
      4'h8: alu_res = SrcA >> shamt;
      4'h9: alu_res = $signed(SrcA) >>> shamt;
      default: alu_ill = 1'b1;
    endcase
  end

  // One multiply or divide step; a zero divisor naturally yields all-ones / dividend
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : {(WIDTH+1){1'b0}});
    rsh   = {hi_q, lo_q[WIDTH-1]};
    rdiff = rsh - {1'b0, dv_q};
    if (op_q[2]) begin
      if (rsh >= {1'b0, dv_q}) begin
        step_hi = rdiff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rsh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi) begin
            load    = 1'b1;
            cnt_d   = CW'(WIDTH);
            state_d = CALC;
          end else begin
            result_d = alu_res;
            err_d    = alu_ill;
            done_d   = 1'b1;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = op_q[0] ? step_hi : step_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi_q <= '0;
      lo_q <= SrcA;
      dv_q <= SrcB;
      op_q <= Ctrl;
    end else if (state_q == CALC) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

  assign Result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;
  assign busy   = (state_q == CALC);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] a, b, res;
  logic        zero, err, busy, done;

  logic        start8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8, b8, res8;
  logic        zero8, err8, busy8, done8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .ERR_VAL(32'hDEADBEEF)) dut32 (
    .clk(clk), .rst(rst), .start(start), .Ctrl(ctrl), .SrcA(a), .SrcB(b),
    .Result(res), .zero(zero), .err(err), .busy(busy), .done(done)
  );

  alu_multicycle #(.WIDTH(8), .ERR_VAL(8'hEF)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .Ctrl(ctrl8), .SrcA(a8), .SrcB(b8),
    .Result(res8), .zero(zero8), .err(err8), .busy(busy8), .done(done8)
  );

  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; ctrl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ctrl = 4'h0; a = '0; b = '0;
    start8 = 1'b0; ctrl8 = 4'h0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got res=%h zero=%b err=%b busy=%b done=%b exp res=0 zero=1 err=0 busy=0 done=0",
               res, zero, err, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    issue(4'h0, 32'd5, 32'd7);
    checks++;
    if (res !== 32'd12 || done !== 1'b1 || zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_add got res=%h done=%b zero=%b busy=%b exp res=0000000c done=1 zero=0 busy=0",
               res, done, zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || res !== 32'd12) begin
      errors++;
      $display("FAIL done_pulse_width got done=%b res=%h exp done=0 res=0000000c", done, res);
    end
  endtask

  task automatic test_single_cycle;
    logic [3:0]  tc [9] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'h1, 4'h7, 4'h8};
    logic [31:0] ta [9] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h1, 32'h8000_0000};
    logic [31:0] tb [9] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h1,
                           32'h1, 32'h21, 32'h1, 32'h21, 32'h4};
    logic [31:0] te [9] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h1,
                           32'h0, 32'hC000_0000, 32'hFFFF_FFFF, 32'h2, 32'h0800_0000};
    // Issued on consecutive cycles, so done must stay high throughout
    for (int i = 0; i < 9; i++) begin
      issue(tc[i], ta[i], tb[i]);
      checks++;
      if (res !== te[i] || done !== 1'b1 || busy !== 1'b0 || zero !== (te[i] == 32'h0)) begin
        errors++;
        $display("FAIL single_op%0d ctrl=%h got res=%h done=%b busy=%b zero=%b exp res=%h done=1 busy=0",
                 i, tc[i], res, done, busy, zero, te[i]);
      end
    end
  endtask

  task automatic test_multiply;
    int cyc;
    issue(4'hA, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 32 || res !== 32'hFFFF_FFFE || busy !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_result got cyc=%0d res=%h busy=%b zero=%b exp cyc=32 res=fffffffe busy=0 zero=0",
               cyc, res, busy, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse got done=%b exp 0", done);
    end
    issue(4'hB, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
    checks++;
    if (cyc != 32 || res !== 32'd1) begin
      errors++;
      $display("FAIL mulhu_result got cyc=%0d res=%h exp cyc=32 res=00000001", cyc, res);
    end
  endtask

  task automatic test_divide;
    int cyc;
    logic [3:0]  tc [4] = '{4'hC, 4'hD, 4'hC, 4'hD};
    logic [31:0] ta [4] = '{32'd100, 32'd100, 32'd12345, 32'd9};
    logic [31:0] tb [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] te [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 4; i++) begin
      issue(tc[i], ta[i], tb[i]);
      wait_done(cyc);
      checks++;
      if (cyc != 32 || res !== te[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL div_case%0d got cyc=%0d res=%h err=%b exp cyc=32 res=%h err=0", i, cyc, res, err, te[i]);
      end
    end
    // Start pulses and operand changes during CALC must be ignored
    issue(4'hC, 32'd100, 32'd7);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      start = (cyc < 5); ctrl = 4'h0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 32 || res !== 32'd14) begin
      errors++;
      $display("FAIL div_ignore_start got cyc=%0d res=%h exp cyc=32 res=0000000e", cyc, res);
    end
    issue(4'h0, 32'd3, 32'd4);
    checks++;
    if (res !== 32'd7 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_in_done got res=%h done=%b busy=%b exp res=00000007 done=1 busy=0", res, done, busy);
    end
  endtask

  task automatic test_illegal;
    issue(4'hF, 32'd1, 32'd2);
    checks++;
    if (res !== 32'hDEADBEEF || err !== 1'b1 || zero !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL illegal_f got res=%h err=%b zero=%b done=%b exp res=deadbeef err=1 zero=0 done=1",
               res, err, zero, done);
    end
    issue(4'hE, 32'd1, 32'd2);
    checks++;
    if (res !== 32'hDEADBEEF || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_e got res=%h err=%b exp res=deadbeef err=1", res, err);
    end
    issue(4'h0, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (res !== 32'h0 || err !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got res=%h err=%b zero=%b exp res=00000000 err=0 zero=1", res, err, zero);
    end
  endtask

  task automatic test_reset_mid_op;
    bit seen_done = 0;
    issue(4'h0, 32'd3, 32'd3);
    issue(4'hC, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div got res=%h zero=%b err=%b busy=%b done=%b exp res=0 zero=1 err=0 busy=0 done=0",
               res, zero, err, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1;
    end
    checks++;
    if (seen_done !== 1'b0 || res !== 32'h0) begin
      errors++;
      $display("FAIL abort_no_done got seen=%b res=%h exp seen=0 res=00000000", seen_done, res);
    end
  endtask

  task automatic test_param_sweep;
    int cyc;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start8 = 1'b1; ctrl8 = (k == 0) ? 4'hA : 4'hB; a8 = 8'h10; b8 = 8'h10;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc != 8 || res8 !== ((k == 0) ? 8'h00 : 8'h01) || zero8 !== (k == 0) || err8 !== 1'b0) begin
        errors++;
        $display("FAIL w8_mul%0d got cyc=%0d res=%h zero=%b err=%b exp cyc=8 res=%h zero=%b",
                 k, cyc, res8, zero8, err8, (k == 0) ? 8'h00 : 8'h01, (k == 0));
      end
    end
    @(negedge clk);
    start8 = 1'b1; ctrl8 = 4'hF;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (res8 !== 8'hEF || err8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_illegal got res=%h err=%b exp res=ef err=1", res8, err8);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multiply();
    test_divide();
    test_illegal();
    test_reset_mid_op();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
